// File: rtl/ti_lut_share_pipe.sv
// Threshold-implementation share LUTs: NSHARE independent runtime-loadable tables,
// evaluated through a two-register valid/ready pipeline with no cross-share logic.
module ti_lut_share_pipe #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 1,
    parameter int NSHARE = 3,
    parameter int SEL_W  = (NSHARE > 1) ? $clog2(NSHARE) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NSHARE*IN_W-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NSHARE*OUT_W-1:0]   out_data,
    input  logic                      cfg_we,
    input  logic [SEL_W-1:0]          cfg_sel,
    input  logic [IN_W-1:0]           cfg_addr,
    input  logic [OUT_W-1:0]          cfg_wdata,
    input  logic                      cfg_done,
    input  logic                      cfg_reload,
    output logic                      mode_run,
    output logic                      cfg_err
);

    localparam logic [31:0] NSHARE_U = 32'(NSHARE);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e                    state_q, state_d;
    logic                      s1_valid_q, s1_valid_d;
    logic                      s2_valid_q, s2_valid_d;
    logic [NSHARE*IN_W-1:0]    s1_data_q;
    logic [NSHARE*OUT_W-1:0]   s2_data_q;
    logic [NSHARE*OUT_W-1:0]   lookup;
    logic                      cfg_err_q, cfg_err_d;
    logic                      sel_ok;
    logic                      lut_we;
    logic                      s2_adv;
    logic                      accept;

    logic [OUT_W-1:0]          lut_q [NSHARE][2**IN_W];

    assign sel_ok    = (32'(cfg_sel) < NSHARE_U);
    assign lut_we    = cfg_we && sel_ok && (state_q == ST_LOAD);

    assign s2_adv    = !s2_valid_q || out_ready;
    assign in_ready  = (state_q == ST_RUN) && (!s1_valid_q || s2_adv);
    assign accept    = in_valid && in_ready;

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign mode_run  = (state_q == ST_RUN);
    assign cfg_err   = cfg_err_q;

    // Tables are never reset; contents are only meaningful once loaded.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_q[cfg_sel][cfg_addr] <= cfg_wdata;
        end
    end

    // Each share indexes only its own table.
    always_comb begin
        lookup = '0;
        for (int j = 0; j < NSHARE; j++) begin
            lookup[j*OUT_W +: OUT_W] = lut_q[j][s1_data_q[j*IN_W +: IN_W]];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (cfg_done)                  state_d = ST_RUN;
            ST_RUN:   if (cfg_reload)                state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = ST_LOAD;
            default:                                 state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        cfg_err_d  = cfg_err_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (cfg_we && (!sel_ok || (state_q != ST_LOAD))) begin
            cfg_err_d = 1'b1;
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cfg_err_q  <= cfg_err_d;
            if (s2_adv && s1_valid_q) begin
                s2_data_q <= lookup;
            end
        end
    end

    // Stage-1 share register: glitch barrier between input shares and the tables.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_data_q <= in_data;
        end
    end

endmodule

// File: tb/tb_ti_lut_share_pipe.sv
// Scoreboard bench for ti_lut_share_pipe: table load, streaming, backpressure,
// config errors, reload/drain and asynchronous reset.
module tb_ti_lut_share_pipe;

    localparam int IN_W   = 8;
    localparam int OUT_W  = 1;
    localparam int NSHARE = 3;
    localparam int SEL_W  = 2;
    localparam int DW     = NSHARE * IN_W;
    localparam int OW     = NSHARE * OUT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_data;
    logic             cfg_we;
    logic [SEL_W-1:0] cfg_sel;
    logic [IN_W-1:0]  cfg_addr;
    logic [OUT_W-1:0] cfg_wdata;
    logic             cfg_done;
    logic             cfg_reload;
    logic             mode_run;
    logic             cfg_err;

    int tests = 0;
    int fails = 0;

    logic [OUT_W-1:0] lut_m [NSHARE][2**IN_W];
    logic [OW-1:0]    sb_q [$];

    ti_lut_share_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NSHARE(NSHARE), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_done(cfg_done), .cfg_reload(cfg_reload),
        .mode_run(mode_run), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [OW-1:0] model(input logic [DW-1:0] d);
        logic [OW-1:0] r;
        r = '0;
        for (int j = 0; j < NSHARE; j++) r[j*OUT_W +: OUT_W] = lut_m[j][d[j*IN_W +: IN_W]];
        return r;
    endfunction

    // Loads LUT_j[x] = bit j of x; optionally raises cfg_done with the last write.
    task automatic load_tables(input bit with_done);
        for (int j = 0; j < NSHARE; j++) begin
            for (int x = 0; x < 2**IN_W; x++) begin
                logic [31:0] xv;
                xv = 32'(x);
                @(negedge clk);
                cfg_we    = 1'b1;
                cfg_sel   = SEL_W'(j);
                cfg_addr  = IN_W'(x);
                cfg_wdata = xv[j];
                cfg_done  = with_done && (j == NSHARE-1) && (x == 2**IN_W-1);
                lut_m[j][x] = xv[j];
            end
        end
        @(negedge clk);
        cfg_we   = 1'b0;
        cfg_done = 1'b0;
    endtask

    task automatic send_check(input logic [DW-1:0] d, input logic [OW-1:0] exp, input string tag);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL %s_accept: in_ready=%b required 1", tag, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL %s_latency: out_valid=%b one cycle after accept, required 0", tag, out_valid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            fails++; $display("FAIL %s_data: out_valid=%b out_data=%b required valid=1 data=%b", tag, out_valid, out_data, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || mode_run !== 1'b0 || cfg_err !== 1'b0 || out_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: vld=%b rdy=%b run=%b err=%b data=%b required all 0",
                     out_valid, in_ready, mode_run, cfg_err, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0 || mode_run !== 1'b0) begin
            fails++; $display("FAIL reset_load_state: in_ready=%b mode_run=%b required 0/0", in_ready, mode_run);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        load_tables(1'b1);
        #1;
        tests++;
        if (mode_run !== 1'b1) begin
            fails++; $display("FAIL basic_run: mode_run=%b required 1", mode_run);
        end
        send_check({8'h04, 8'h02, 8'h01}, 3'b111, "basic_ones");
        send_check({8'hFB, 8'hFD, 8'hFE}, 3'b000, "basic_zeros");
        send_check({8'hFF, 8'h00, 8'h00}, 3'b100, "basic_last_entry");
    endtask

    task automatic stream(input int n, input int rdy_pct, input int vld_pct, input bit gapless, input string tag);
        int sent = 0;
        int rcvd = 0;
        int cyc = 0;
        bit pend = 1'b0;
        bit stalled = 1'b0;
        logic [OW-1:0] held = '0;
        logic [OW-1:0] exp;
        logic exp_rdy;
        while ((sent < n || rcvd < n) && cyc < 3000) begin
            @(negedge clk);
            if (!pend) begin
                if (sent < n && $urandom_range(99) < vld_pct) begin
                    in_valid = 1'b1;
                    in_data  = DW'($urandom());
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            exp_rdy = mode_run && ((sb_q.size() < 2) || out_ready);
            tests++;
            if (in_ready !== exp_rdy) begin
                fails++; $display("FAIL %s_in_ready: cycle %0d in_ready=%b required %b", tag, cyc, in_ready, exp_rdy);
            end
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    fails++; $display("FAIL %s_hold: vld=%b data=%b required vld=1 data=%b", tag, out_valid, out_data, held);
                end
            end
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL %s_extra: output %b with empty scoreboard, required none", tag, out_data);
                end else if (out_ready) begin
                    exp = sb_q.pop_front();
                    rcvd++;
                    tests++;
                    if (out_data !== exp) begin
                        fails++; $display("FAIL %s_data: item %0d out_data=%b required %b", tag, rcvd, out_data, exp);
                    end
                end
            end else if (gapless && rcvd > 0 && rcvd < n) begin
                tests++; fails++;
                $display("FAIL %s_gap: out_valid=0 at cycle %0d, required 1", tag, cyc);
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held = out_data;
            pend = in_valid && !in_ready;
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_data));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (rcvd != n || sb_q.size() != 0) begin
            fails++; $display("FAIL %s_count: received %0d left %0d, required %0d and 0", tag, rcvd, sb_q.size(), n);
        end
        sb_q.delete();
    endtask

    task automatic test_back_to_back();
        stream(64, 100, 100, 1'b1, "b2b");
    endtask

    task automatic test_backpressure();
        stream(64, 50, 70, 1'b0, "bp");
    endtask

    task automatic test_cfg_err_run();
        @(negedge clk);
        #1;
        tests++;
        if (cfg_err !== 1'b0) begin
            fails++; $display("FAIL err_pre: cfg_err=%b required 0", cfg_err);
        end
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 8'h01; cfg_wdata = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        tests++;
        if (cfg_err !== 1'b1 || mode_run !== 1'b1) begin
            fails++; $display("FAIL err_run_write: cfg_err=%b mode_run=%b required 1/1", cfg_err, mode_run);
        end
        send_check({8'h00, 8'h00, 8'h01}, 3'b001, "err_run_readback");
    endtask

    task automatic test_reload();
        logic [DW-1:0] a, b;
        logic [OW-1:0] ea, eb;
        a = DW'($urandom());
        b = DW'($urandom());
        ea = model(a);
        eb = model(b);
        @(negedge clk);
        in_valid = 1'b1; in_data = a; out_ready = 1'b0;
        @(negedge clk);
        in_data = b;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reload_fill: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; cfg_reload = 1'b1;
        @(negedge clk);
        cfg_reload = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0 || mode_run !== 1'b0 || out_valid !== 1'b1 || out_data !== ea) begin
                fails++;
                $display("FAIL reload_stall: cyc %0d rdy=%b run=%b vld=%b data=%b required 0/0/1/%b",
                         i, in_ready, mode_run, out_valid, out_data, ea);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== ea) begin
            fails++; $display("FAIL reload_first: vld=%b data=%b required 1/%b", out_valid, out_data, ea);
        end
        @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== eb) begin
            fails++; $display("FAIL reload_second: vld=%b data=%b required 1/%b", out_valid, out_data, eb);
        end
        @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || mode_run !== 1'b0) begin
            fails++; $display("FAIL reload_drained: vld=%b run=%b required 0/0", out_valid, mode_run);
        end
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 8'h00; cfg_wdata = 1'b1;
        lut_m[0][0] = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b1; in_data = '0;
        #1;
        tests++;
        if (in_ready !== 1'b0 || mode_run !== 1'b0) begin
            fails++; $display("FAIL reload_load_state: rdy=%b run=%b required 0/0", in_ready, mode_run);
        end
        in_valid = 1'b0; cfg_done = 1'b1;
        @(negedge clk);
        cfg_done = 1'b0;
        #1;
        tests++;
        if (mode_run !== 1'b1) begin
            fails++; $display("FAIL reload_rerun: mode_run=%b required 1", mode_run);
        end
        send_check({8'h00, 8'h00, 8'h00}, 3'b001, "reload_new_entry");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = DW'($urandom()); out_ready = 1'b0;
        @(negedge clk);
        in_data = DW'($urandom());
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || mode_run !== 1'b1) begin
            fails++; $display("FAIL areset_pre: vld=%b run=%b required 1/1", out_valid, mode_run);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || mode_run !== 1'b0 || out_data !== '0 || cfg_err !== 1'b0) begin
            fails++;
            $display("FAIL areset_immediate: vld=%b rdy=%b run=%b data=%b err=%b required all 0",
                     out_valid, in_ready, mode_run, out_data, cfg_err);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || mode_run !== 1'b0) begin
            fails++; $display("FAIL areset_release: vld=%b run=%b required 0/0", out_valid, mode_run);
        end
    endtask

    task automatic test_sel_range();
        load_tables(1'b0);
        #1;
        tests++;
        if (cfg_err !== 1'b0) begin
            fails++; $display("FAIL sel_pre: cfg_err=%b required 0", cfg_err);
        end
        cfg_we = 1'b1; cfg_sel = 2'd3; cfg_addr = 8'h02; cfg_wdata = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        tests++;
        if (cfg_err !== 1'b1) begin
            fails++; $display("FAIL sel_err: cfg_err=%b required 1", cfg_err);
        end
        cfg_done = 1'b1;
        @(negedge clk);
        cfg_done = 1'b0;
        send_check({8'h02, 8'h02, 8'h02}, 3'b010, "sel_readback");
        #1;
        tests++;
        if (cfg_err !== 1'b1) begin
            fails++; $display("FAIL sel_sticky: cfg_err=%b required 1", cfg_err);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
        cfg_done = 1'b0; cfg_reload = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_cfg_err_run();
        test_reload();
        test_async_reset();
        test_sel_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
